// File: rtl/adder4_accum.sv
// Frames N_SAMPLES results {in_c,in_sum} from a 4-bit adder into an ACC_W-bit total with overflow flag.
// Build option: define ADDER4_ACCUM_SAT_EN to clamp at 2^ACC_W-1 instead of wrapping.
module adder4_accum #(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned ACC_W     = 8
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [7:0]       N_LAST  = 8'(N_SAMPLES);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [7:0]       cnt_inc;
  logic             ovf, ovf_nxt;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] add_res;
  logic             carry;

  assign operand  = ACC_W'({in_c, in_sum});
  assign add_full = {1'b0, acc} + {1'b0, operand};
  assign carry    = add_full[ACC_W];
  assign cnt_inc  = cnt + 8'd1;

`ifdef ADDER4_ACCUM_SAT_EN
  // Once clamped, any nonzero operand carries again, so acc stays pinned at max.
  assign add_res = carry ? ACC_MAX : add_full[ACC_W-1:0];
`else
  assign add_res = add_full[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_nxt   = operand;
          cnt_nxt   = 8'd1;
          ovf_nxt   = 1'b0;
          state_nxt = (N_LAST == 8'd1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_nxt = add_res;
          cnt_nxt = cnt_inc;
          ovf_nxt = ovf | carry;
          if (cnt_inc == N_LAST) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_total = acc;
  assign out_ovf   = (state == HOLD) && ovf;
  assign busy      = (state == ACCUM);

endmodule

// File: tb/tb_adder4_accum.sv
// Directed bench for adder4_accum: three instances (N=4, N=16, N=1) checked each cycle against a frame-level model.
module tb_adder4_accum;

  localparam int NS [3] = '{4, 16, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid, in_ready, out_valid, out_ready, out_ovf, busy, in_c;
  logic [3:0] in_sum [3];
  logic [7:0] out_total [3];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  checking = 1'b0;

  // Frame-level model: operand count in the open frame, plain integer sum, pending flag.
  int  m_cnt [3];
  int  m_sum [3];
  bit  m_hold [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adder4_accum #(.N_SAMPLES(NS[g]), .ACC_W(8)) u_dut (
      .clk1(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_sum(in_sum[g]), .in_c(in_c[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_total(out_total[g]), .out_ovf(out_ovf[g]), .busy(busy[g])
    );
  end

  function automatic int exp_total(input int s);
`ifdef ADDER4_ACCUM_SAT_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        m_hold[g] <= 1'b0;
        m_cnt[g]  <= 0;
        m_sum[g]  <= 0;
      end else if (m_hold[g]) begin
        if (out_ready[g]) m_hold[g] <= 1'b0;
      end else if (in_valid[g]) begin
        m_sum[g] <= ((m_cnt[g] == 0) ? 0 : m_sum[g]) + int'({in_c[g], in_sum[g]});
        if (m_cnt[g] + 1 == NS[g]) begin
          m_hold[g] <= 1'b1;
          m_cnt[g]  <= 0;
        end else begin
          m_cnt[g] <= m_cnt[g] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("g%0d in_ready", g),  int'(in_ready[g]),  int'(!m_hold[g]));
        chk($sformatf("g%0d out_valid", g), int'(out_valid[g]), int'(m_hold[g]));
        chk($sformatf("g%0d busy", g),      int'(busy[g]),      int'(!m_hold[g] && m_cnt[g] > 0));
        chk($sformatf("g%0d out_total", g), int'(out_total[g]), exp_total(m_sum[g]));
        chk($sformatf("g%0d out_ovf", g),   int'(out_ovf[g]),   int'(m_hold[g] && m_sum[g] > 255));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int g, input int op);
    logic [4:0] v;
    v = op[4:0];
    in_valid[g] = 1'b1;
    in_sum[g]   = v[3:0];
    in_c[g]     = v[4];
  endtask

  task automatic xfer(input int g, input int op);
    put(g, op);
    cyc();
    in_valid[g] = 1'b0;
  endtask

  task automatic release_frame(input int g);
    out_ready[g] = 1'b1;
    cyc();
    out_ready[g] = 1'b0;
    chk("release out_valid", int'(out_valid[g]), 0);
    chk("release in_ready",  int'(in_ready[g]), 1);
  endtask

  initial begin
    int ops [4];
    int waited;
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    in_c = '0;
    for (int g = 0; g < 3; g++) in_sum[g] = '0;
    repeat (2) cyc();
    checking = 1'b1;
    chk("reset out_valid", int'(out_valid[0]), 0);
    chk("reset out_total", int'(out_total[0]), 0);
    chk("reset out_ovf",   int'(out_ovf[0]), 0);
    chk("reset busy",      int'(busy[0]), 0);
    chk("reset in_ready",  int'(in_ready[0]), 1);
    rst = 1'b0;

    // 5,10,15,31 back to back
    ops = '{5, 10, 15, 31};
    for (int i = 0; i < 3; i++) begin
      put(0, ops[i]);
      cyc();
    end
    chk("basic valid before 4th", int'(out_valid[0]), 0);
    xfer(0, ops[3]);
    chk("basic out_valid", int'(out_valid[0]), 1);
    chk("basic out_total", int'(out_total[0]), 61);
    chk("basic out_ovf",   int'(out_ovf[0]), 0);
    release_frame(0);

    // Stall in HOLD with ignored input pulses
    ops = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) xfer(0, ops[i]);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) put(0, 7);
      else in_valid[0] = 1'b0;
      cyc();
      chk("stall out_valid", int'(out_valid[0]), 1);
      chk("stall out_total", int'(out_total[0]), 10);
      chk("stall in_ready",  int'(in_ready[0]), 0);
    end
    in_valid[0] = 1'b0;
    release_frame(0);
    chk("after stall busy", int'(busy[0]), 0);

    // Gapped valid; data on idle cycles is garbage
    ops = '{3, 6, 9, 12};
    for (int i = 0; i < 4; i++) begin
      xfer(0, ops[i]);
      if (i < 3) begin
        in_sum[0] = 4'hF;
        in_c[0]   = 1'b1;
        cyc();
      end
    end
    chk("gapped out_total", int'(out_total[0]), 30);
    chk("gapped out_valid", int'(out_valid[0]), 1);
    release_frame(0);

    // Reset mid-frame discards partial sum
    xfer(0, 9);
    xfer(0, 9);
    chk("pre-reset busy", int'(busy[0]), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid reset busy",      int'(busy[0]), 0);
    chk("mid reset out_valid", int'(out_valid[0]), 0);
    for (int i = 0; i < 4; i++) xfer(0, 1);
    chk("post reset out_total", int'(out_total[0]), 4);
    release_frame(0);

    // N=16, sixteen operands of 31
    for (int i = 0; i < 16; i++) xfer(1, 31);
    waited = 0;
    while (!out_valid[1] && waited < 20) begin
      cyc();
      waited++;
    end
    chk("n16 hold timeout", int'(out_valid[1]), 1);
`ifdef ADDER4_ACCUM_SAT_EN
    chk("n16 out_total", int'(out_total[1]), 255);
`else
    chk("n16 out_total", int'(out_total[1]), 240);
`endif
    chk("n16 out_ovf", int'(out_ovf[1]), 1);
    release_frame(1);
    chk("n16 ovf cleared", int'(out_ovf[1]), 0);

    // N=1, operand 17
    xfer(2, 17);
    chk("n1 out_valid", int'(out_valid[2]), 1);
    chk("n1 out_total", int'(out_total[2]), 17);
    chk("n1 busy",      int'(busy[2]), 0);
    release_frame(2);

    repeat (2) cyc();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end

endmodule

// File: doc/adder4_accum.md
ADDER4_ACCUM -- requirements
Module: adder4_accum

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 4, giving the number of adder results per frame (legal 1..255).
REQ-002 The block SHALL have parameter ACC_W, default 8, giving the accumulator and total width (legal 5..16).
REQ-003 The block SHALL have port clk1  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  an adder result is present on in_sum/in_c.
REQ-006 The block SHALL have port in_ready  output  1  the block accepts a result this cycle.
REQ-007 The block SHALL have port in_sum  input  4  Sum[3:0] from the upstream 4-bit adder.
REQ-008 The block SHALL have port in_c  input  1  carry-out C from the upstream 4-bit adder.
REQ-009 The block SHALL have port out_valid  output  1  the frame total is presented.
REQ-010 The block SHALL have port out_ready  input  1  the downstream consumer takes the total.
REQ-011 The block SHALL have port out_total  output  ACC_W  the frame total.
REQ-012 The block SHALL have port out_ovf  output  1  the frame total exceeded 2^ACC_W-1.
REQ-013 The block SHALL have port busy  output  1  a frame is partially accumulated (state ACCUM).

Function
REQ-014 The operand SHALL be {in_c,in_sum}, zero-extended to ACC_W bits, range 0..31.
REQ-015 A transfer SHALL occur on a clk1 edge where in_valid and in_ready are both 1; data with in_ready=0 is ignored.
REQ-016 The FSM SHALL have the states IDLE, ACCUM and HOLD.
REQ-017 In IDLE and ACCUM, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0, with no dependence on out_ready.
REQ-018 On a transfer in IDLE, acc SHALL load the operand, cnt SHALL be set to 1, ovf SHALL clear, and the next state SHALL be ACCUM (HOLD if N_SAMPLES=1).
REQ-019 On a transfer in ACCUM, acc SHALL become acc+operand and cnt SHALL increment; the next state SHALL be HOLD when the incremented cnt equals N_SAMPLES.
REQ-020 Cycles without a transfer SHALL leave acc, cnt and the state unchanged.
REQ-021 In HOLD, out_valid SHALL be 1, and out_total and out_ovf SHALL be held stable until the cycle after out_ready=1.
REQ-022 In HOLD with out_ready=1, the next state SHALL be IDLE.
REQ-023 out_valid SHALL first assert on the cycle after the Nth transfer; the minimum frame period SHALL be N_SAMPLES+1 cycles.
REQ-024 In wrap mode, the sum SHALL be taken modulo 2^ACC_W, and ovf SHALL set sticky for the frame on any carry out of bit ACC_W-1.
REQ-025 out_total SHALL equal acc and busy SHALL equal (state==ACCUM); out_valid and out_ovf SHALL be 0 outside HOLD.

Reset
REQ-026 When rst=1 at a clk1 edge, the state SHALL go to IDLE, acc and cnt SHALL go to 0, and ovf SHALL clear; rst SHALL take priority over any transfer in the same cycle.
REQ-027 After reset, the outputs SHALL be out_valid=0, out_total=0, out_ovf=0, busy=0 and in_ready=1.
REQ-028 A reset during ACCUM or HOLD SHALL discard the partial or pending frame without emitting it.

Configuration
REQ-029 When ADDER4_ACCUM_SAT_EN is defined, an add that would exceed 2^ACC_W-1 SHALL clamp acc to 2^ACC_W-1 and set ovf, and further adds in that frame SHALL keep acc clamped.
REQ-030 When ADDER4_ACCUM_SAT_EN is undefined, the wrap behaviour of REQ-024 SHALL apply; the interface SHALL be identical in both builds.

Verification
REQ-031 The bench SHALL cover: N=4, ACC_W=8, operands 5,10,15,31 on consecutive cycles -> out_valid=1 one cycle after the 4th transfer, out_total=61, out_ovf=0.
REQ-032 The bench SHALL cover: N=16, ACC_W=8, sixteen operands of 31 (in_c=1, in_sum=15) -> without SAT_EN, out_total=240 and out_ovf=1; with SAT_EN, out_total=255 and out_ovf=1.
REQ-033 The bench SHALL cover: a frame completed with out_ready held 0 for 5 cycles -> out_valid held, out_total stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE the next cycle.
REQ-034 The bench SHALL cover: N=4 with in_valid deasserted on alternate cycles -> only asserted cycles accumulate, and the total is correct after 4 transfers.
REQ-035 The bench SHALL cover: rst pulsed after 2 of 4 transfers -> busy=0 and out_valid=0, and the next 4 operands of 1 give out_total=4.
REQ-036 The bench SHALL cover: N=1, operand 17 -> HOLD after one transfer, out_total=17.
